// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select and load-use stall control for a 5-stage pipeline.
// Optional saturating stall counter enabled by defining HAZARD_STALL_CNT_EN.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rt_i,
  input  logic [REG_ADDR_W-1:0] id_dst_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic                  flush_i,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o,
`ifdef HAZARD_STALL_CNT_EN
  output logic [CNT_W-1:0]      stall_cnt_o,
`endif
  output logic                  stall_o
);

  logic [REG_ADDR_W-1:0] idex_rs_q, idex_rs_d;
  logic [REG_ADDR_W-1:0] idex_rt_q, idex_rt_d;
  logic [REG_ADDR_W-1:0] idex_dst_q, idex_dst_d;
  logic                  idex_rw_q, idex_rw_d;
  logic                  idex_mr_q, idex_mr_d;
  logic                  idex_valid_q, idex_valid_d;
  logic [REG_ADDR_W-1:0] exmem_dst_q, memwb_dst_q;
  logic                  exmem_rw_q, memwb_rw_q;
  logic                  bubble;

  assign stall_o = id_valid_i && !flush_i && idex_mr_q && (idex_dst_q != '0) &&
                   ((idex_dst_q == id_rs_i) || (id_uses_rt_i && (idex_dst_q == id_rt_i)));

  assign bubble = stall_o || flush_i || !id_valid_i;

  always_comb begin
    idex_rs_d    = '0;
    idex_rt_d    = '0;
    idex_dst_d   = '0;
    idex_rw_d    = 1'b0;
    idex_mr_d    = 1'b0;
    idex_valid_d = 1'b0;
    if (!bubble) begin
      idex_rs_d    = id_rs_i;
      idex_rt_d    = id_rt_i;
      idex_dst_d   = id_dst_i;
      idex_rw_d    = id_reg_write_i;
      idex_mr_d    = id_mem_read_i;
      idex_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex_rs_q    <= '0;
      idex_rt_q    <= '0;
      idex_dst_q   <= '0;
      idex_rw_q    <= 1'b0;
      idex_mr_q    <= 1'b0;
      idex_valid_q <= 1'b0;
      exmem_dst_q  <= '0;
      exmem_rw_q   <= 1'b0;
      memwb_dst_q  <= '0;
      memwb_rw_q   <= 1'b0;
    end else begin
      idex_rs_q    <= idex_rs_d;
      idex_rt_q    <= idex_rt_d;
      idex_dst_q   <= idex_dst_d;
      idex_rw_q    <= idex_rw_d;
      idex_mr_q    <= idex_mr_d;
      idex_valid_q <= idex_valid_d;
      exmem_dst_q  <= idex_dst_q;
      exmem_rw_q   <= idex_rw_q;
      memwb_dst_q  <= exmem_dst_q;
      memwb_rw_q   <= exmem_rw_q;
    end
  end

  // EX/MEM is the younger producer, so it is checked first.
  always_comb begin
    fwd_a_sel_o = 2'b00;
    fwd_b_sel_o = 2'b00;
    if (idex_valid_q) begin
      if (exmem_rw_q && (exmem_dst_q != '0) && (exmem_dst_q == idex_rs_q)) begin
        fwd_a_sel_o = 2'b01;
      end else if (memwb_rw_q && (memwb_dst_q != '0) && (memwb_dst_q == idex_rs_q)) begin
        fwd_a_sel_o = 2'b10;
      end
      if (exmem_rw_q && (exmem_dst_q != '0) && (exmem_dst_q == idex_rt_q)) begin
        fwd_b_sel_o = 2'b01;
      end else if (memwb_rw_q && (memwb_dst_q != '0) && (memwb_dst_q == idex_rt_q)) begin
        fwd_b_sel_o = 2'b10;
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed self-checking bench for fwd_hazard_ctrl (covers HAZARD_STALL_CNT_EN when defined).
module tb_fwd_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       id_valid_i;
  logic [4:0] id_rs_i, id_rt_i, id_dst_i;
  logic       id_uses_rt_i, id_reg_write_i, id_mem_read_i, flush_i;
  logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
  logic       stall_o;
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  fwd_hazard_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_uses_rt_i  (id_uses_rt_i),
    .id_dst_i      (id_dst_i),
    .id_reg_write_i(id_reg_write_i),
    .id_mem_read_i (id_mem_read_i),
    .flush_i       (flush_i),
    .fwd_a_sel_o   (fwd_a_sel_o),
    .fwd_b_sel_o   (fwd_b_sel_o),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cnt_o   (stall_cnt_o),
`endif
    .stall_o       (stall_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] dst, input logic rw,
                        input logic mr);
    id_valid_i     = v;
    id_rs_i        = rs;
    id_rt_i        = rt;
    id_uses_rt_i   = urt;
    id_dst_i       = dst;
    id_reg_write_i = rw;
    id_mem_read_i  = mr;
    #1;
  endtask

  task automatic do_reset();
    flush_i = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst_i = 1'b1;
    #1;
    checks++;
    if (fwd_a_sel_o !== 2'b00 || fwd_b_sel_o !== 2'b00 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: a=%b b=%b stall=%b expected 00 00 0",
               fwd_a_sel_o, fwd_b_sel_o, stall_o);
    end
    tick();
    rst_i = 1'b0;
    set_id(1'b1, 5'd3, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    checks++;
    if (fwd_a_sel_o !== 2'b00 || fwd_b_sel_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_first_instr: a=%b b=%b expected 00 00", fwd_a_sel_o, fwd_b_sel_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    checks++;
    if (fwd_a_sel_o !== 2'b00 || fwd_b_sel_o !== 2'b00) begin
      errors++;
      $display("FAIL b2b_producer: a=%b b=%b expected 00 00", fwd_a_sel_o, fwd_b_sel_o);
    end
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall: stall=%b expected 0", stall_o);
    end
    tick();
    checks++;
    if (fwd_a_sel_o !== 2'b01 || fwd_b_sel_o !== 2'b00) begin
      errors++;
      $display("FAIL b2b_consumer: a=%b b=%b expected 01 00", fwd_a_sel_o, fwd_b_sel_o);
    end
  endtask

  task automatic test_double_hazard();
    do_reset();
    set_id(1'b1, 5'd1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd2, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    checks++;
    if (fwd_a_sel_o !== 2'b01 || fwd_b_sel_o !== 2'b00) begin
      errors++;
      $display("FAIL double_priority: a=%b b=%b expected 01 00", fwd_a_sel_o, fwd_b_sel_o);
    end
    do_reset();
    set_id(1'b1, 5'd1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd2, 5'd2, 1'b1, 5'd9, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    checks++;
    if (fwd_a_sel_o !== 2'b10 || fwd_b_sel_o !== 2'b10) begin
      errors++;
      $display("FAIL older_only: a=%b b=%b expected 10 10", fwd_a_sel_o, fwd_b_sel_o);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd8, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: stall=%b expected 1", stall_o);
    end
    tick();
    checks++;
    if (stall_o !== 1'b0 || fwd_a_sel_o !== 2'b00 || fwd_b_sel_o !== 2'b00) begin
      errors++;
      $display("FAIL load_use_bubble: stall=%b a=%b b=%b expected 0 00 00",
               stall_o, fwd_a_sel_o, fwd_b_sel_o);
    end
    tick();
    checks++;
    if (fwd_a_sel_o !== 2'b10 || fwd_b_sel_o !== 2'b00) begin
      errors++;
      $display("FAIL load_use_fwd: a=%b b=%b expected 10 00", fwd_a_sel_o, fwd_b_sel_o);
    end
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd1, 5'd8, 1'b0, 5'd9, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL load_rt_unused: stall=%b expected 0", stall_o);
    end
    set_id(1'b1, 5'd1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL load_rt_used: stall=%b expected 1", stall_o);
    end
  endtask

  task automatic test_r0();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    checks++;
    if (fwd_a_sel_o !== 2'b00 || fwd_b_sel_o !== 2'b00) begin
      errors++;
      $display("FAIL r0_no_fwd: a=%b b=%b expected 00 00", fwd_a_sel_o, fwd_b_sel_o);
    end
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL r0_no_stall: stall=%b expected 0", stall_o);
    end
  endtask

  task automatic test_flush_vs_stall();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    flush_i = 1'b1;
    set_id(1'b1, 5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: stall=%b expected 0", stall_o);
    end
    tick();
    flush_i = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (fwd_a_sel_o !== 2'b00 || fwd_b_sel_o !== 2'b00 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_bubble: a=%b b=%b stall=%b expected 00 00 0",
               fwd_a_sel_o, fwd_b_sel_o, stall_o);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1'b1, 5'd1, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd8, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 1'b1 || fwd_a_sel_o !== 2'b01) begin
      errors++;
      $display("FAIL mid_stall_setup: stall=%b a=%b expected 1 01", stall_o, fwd_a_sel_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0 || fwd_a_sel_o !== 2'b00 || fwd_b_sel_o !== 2'b00) begin
      errors++;
      $display("FAIL mid_stall_async_reset: stall=%b a=%b b=%b expected 0 00 00",
               stall_o, fwd_a_sel_o, fwd_b_sel_o);
    end
    tick();
    rst_i = 1'b0;
  endtask

`ifdef HAZARD_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd8, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
      tick();
    end
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (stall_cnt_o !== 16'd3) begin
      errors++;
      $display("FAIL stall_cnt_three: cnt=%0d expected 3", stall_cnt_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (stall_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL stall_cnt_reset: cnt=%0d expected 0", stall_cnt_o);
    end
    tick();
    rst_i = 1'b0;
  endtask
`endif

  initial begin
    rst_i   = 1'b1;
    flush_i = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    test_reset();
    test_back_to_back();
    test_double_hazard();
    test_load_use();
    test_r0();
    test_flush_vs_stall();
    test_reset_mid_stall();
`ifdef HAZARD_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
